shift_unit_arbiter: RTL and testbench
=====================================

// Module: shift_unit_arbiter
// PURPOSE
//  Shares one 32-bit barrel shifter between two requesters: req0 = EX-stage ALU
//  shift ops (SLL/SRL/SRA), req1 = LSU byte-lane aligner.
//  Round-robin grant, valid/ready handshake on every channel, one registered
//  response slot with backpressure, and pipeline flush.
//  Sits beside the ALU in EX; the response returns to the requester tagged by rsp_id_o.
// PARAMETERS
//  DATA_W   32  operand/result width
//  SHAMT_W  5   shift-amount width (clog2(DATA_W))
//  TAG_W    4   opaque requester tag, returned unchanged
// PORTS
//  clk_i          in   1        clock, rising edge
//  rst_ni         in   1        asynchronous reset, active-low
//  flush_i        in   1        pipeline flush (branch mispredict / trap)
//  reqN_valid_i   in   1        N=0,1: request valid
//  reqN_ready_o   out  1        N=0,1: request accepted this cycle when valid&ready
//  reqN_op_i      in   2        N=0,1: 00 SLL, 01 SRL, 11 SRA, 10 reserved
//  reqN_data_i    in   DATA_W   N=0,1: operand
//  reqN_shamt_i   in   SHAMT_W  N=0,1: shift amount
//  reqN_tag_i     in   TAG_W    N=0,1: tag
//  rsp_valid_o    out  1        response slot holds a result
//  rsp_ready_i    in   1        consumer takes response when valid&ready
//  rsp_id_o       out  1        requester that owns the response (0/1)
//  rsp_tag_o      out  TAG_W    tag of the accepted request
//  rsp_data_o     out  DATA_W   shift result
// BEHAVIOUR
//  - Reset (rst_ni=0, async): rsp_valid_o=0, rsp_id_o=0, rsp_tag_o=0, rsp_data_o=0,
//    priority pointer = req0. reqN_ready_o=0 while in reset.
//  - Slot state: EMPTY (rsp_valid_o=0) / FULL (rsp_valid_o=1).
//    can_accept = (EMPTY | rsp_ready_i) & ~flush_i.
//  - Grant (comb.): only one valid -> that one; both valid -> pointer side.
//    reqN_ready_o = grantN & can_accept. reqN_ready_o may depend on reqN_valid_i;
//    requesters must not make valid depend on ready.
//  - Pointer update only on an accepted grant: it moves to the other requester.
//    No accept -> pointer holds.
//  - Latency 1: accept in cycle N -> rsp_* valid in cycle N+1.
//    Throughput is 1/cycle while rsp_ready_i=1.
//  - FULL and rsp_ready_i=0: all rsp_* outputs held stable, both readies 0.
//  - FULL, rsp_ready_i=1, new accept in the same cycle: the slot is overwritten,
//    rsp_valid_o stays 1. FULL, rsp_ready_i=1, no accept -> EMPTY.
//  - flush_i=1: no accept that cycle; slot -> EMPTY next cycle, even if
//    rsp_ready_i=0 (the pending result is dropped). The pointer is unchanged.
//  - Arithmetic: SLL = data<<shamt, zero fill. SRL = logical right, zero fill.
//    SRA = right shift with data[DATA_W-1] fill. Reserved 10 -> result = data.
//    shamt=0 -> result = data for every op. Only SHAMT_W bits are used.
//  - Reset mid-operation drops a held result; no response is reissued.
// STRUCTURE
//  - shift_pkg: typedef enum logic[1:0] shift_op_e {SH_SLL=2'b00, SH_SRL=2'b01,
//    SH_RSV=2'b10, SH_SRA=2'b11}; localparams DATA_W, SHAMT_W.
//  - Sub-module shift_core: combinational barrel shifter (a_i, shamt_i, op_i -> s_o).
//    It builds on the team's existing logical-right-shift unit plus SLL/SRA
//    variants. Exactly one instance, fed by the grant mux.
//  - Top level: grant/pointer logic, input mux, response register.
// TESTING
//  - Single req0 SRL data=32'h8000_0000 shamt=31 tag=3 ->
//    next cycle rsp_valid=1, id=0, tag=3, data=32'h0000_0001.
//  - Both valid after reset: req0 SRA 32'hF000_0000>>4 and req1 SLL 32'h1<<31.
//    -> req0 granted first (rsp_data=32'hFF00_0000), then req1 (32'h8000_0000).
//    Both held valid for 4 cycles -> grants alternate 0,1,0,1.
//  - Backpressure: rsp_ready_i=0 for 3 cycles with FULL ->
//    rsp_* stable and both readies 0; on ready=1 a new accept overwrites, no bubble.
//  - Flush with FULL and rsp_ready_i=0, req1 valid ->
//    req1_ready=0 that cycle; rsp_valid=0 next cycle; req1 accepted the cycle after.
//  - Corners: shamt=0 for all ops returns data.
//    Op 2'b10 with data=32'hDEAD_BEEF returns 32'hDEAD_BEEF.
//    SRA 32'h7FFF_FFFF>>31 returns 0.
//  - Async reset asserted mid-FULL ->
//    rsp_valid=0 immediately (no clock edge needed); pointer=req0 after release.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared types and widths for the shift-unit arbiter and its barrel shifter.
// Compile-time declarations only; no latency and no flow control of its own.
package shift_pkg;

    localparam int DATA_W  = 32;
    localparam int SHAMT_W = 5;

    typedef enum logic [1:0] {
        SH_SLL = 2'b00,
        SH_SRL = 2'b01,
        SH_RSV = 2'b10,
        SH_SRA = 2'b11
    } shift_op_e;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_e;

endpackage

// File: rtl/shift_core.sv
// Combinational barrel shifter: SLL, SRL and SRA over one right-shift path.
// Zero latency; no flow control, the result follows the inputs.
module shift_core #(
    parameter int DATA_W  = shift_pkg::DATA_W,
    parameter int SHAMT_W = shift_pkg::SHAMT_W
) (
    input  logic [DATA_W-1:0]  a_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    input  logic [1:0]         op_i,
    output logic [DATA_W-1:0]  s_o
);
    import shift_pkg::*;

    shift_op_e         op;
    logic [DATA_W-1:0] a_rev;
    logic [DATA_W-1:0] srl_in;
    logic [DATA_W-1:0] srl_out;
    logic [DATA_W-1:0] srl_rev;
    logic              fill;

    // SLL runs through the logical right shifter on a bit-reversed operand,
    // so there is only one shifter; SRA adds a sign fill mask on top.
    always_comb begin
        op = shift_op_e'(op_i);
        for (int i = 0; i < DATA_W; i++) begin
            a_rev[i] = a_i[DATA_W-1-i];
        end
        srl_in  = (op == SH_SLL) ? a_rev : a_i;
        fill    = (op == SH_SRA) && a_i[DATA_W-1];
        srl_out = srl_in >> shamt_i;
        if (fill) begin
            srl_out = srl_out | ~({DATA_W{1'b1}} >> shamt_i);
        end
        for (int i = 0; i < DATA_W; i++) begin
            srl_rev[i] = srl_out[DATA_W-1-i];
        end
        case (op)
            SH_SLL:  s_o = srl_rev;
            SH_SRL:  s_o = srl_out;
            SH_SRA:  s_o = srl_out;
            default: s_o = a_i;
        endcase
    end

endmodule

// File: rtl/shift_unit_arbiter.sv
// Round-robin arbiter sharing one barrel shifter between two requesters.
// One-cycle latency into a single response slot; readies drop while the slot is held or on flush.
module shift_unit_arbiter #(
    parameter int DATA_W  = shift_pkg::DATA_W,
    parameter int SHAMT_W = shift_pkg::SHAMT_W,
    parameter int TAG_W   = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               flush_i,

    input  logic               req0_valid_i,
    output logic               req0_ready_o,
    input  logic [1:0]         req0_op_i,
    input  logic [DATA_W-1:0]  req0_data_i,
    input  logic [SHAMT_W-1:0] req0_shamt_i,
    input  logic [TAG_W-1:0]   req0_tag_i,

    input  logic               req1_valid_i,
    output logic               req1_ready_o,
    input  logic [1:0]         req1_op_i,
    input  logic [DATA_W-1:0]  req1_data_i,
    input  logic [SHAMT_W-1:0] req1_shamt_i,
    input  logic [TAG_W-1:0]   req1_tag_i,

    output logic               rsp_valid_o,
    input  logic               rsp_ready_i,
    output logic               rsp_id_o,
    output logic [TAG_W-1:0]   rsp_tag_o,
    output logic [DATA_W-1:0]  rsp_data_o
);
    import shift_pkg::*;

    slot_e              slot_q;
    slot_e              slot_d;
    logic               ptr;
    logic               grant0;
    logic               grant1;
    logic               can_accept;
    logic               accept;
    logic               sel;
    shift_op_e          sel_op;
    logic [DATA_W-1:0]  sel_data;
    logic [SHAMT_W-1:0] sel_shamt;
    logic [TAG_W-1:0]   sel_tag;
    logic [DATA_W-1:0]  shift_res;

    // ptr names the requester that wins when both are valid.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (req0_valid_i && req1_valid_i) begin
            grant0 = ~ptr;
            grant1 = ptr;
        end else begin
            grant0 = req0_valid_i;
            grant1 = req1_valid_i;
        end
    end

    assign can_accept   = ((slot_q == SLOT_EMPTY) || rsp_ready_i) && !flush_i && rst_ni;
    assign req0_ready_o = grant0 && can_accept;
    assign req1_ready_o = grant1 && can_accept;
    assign accept       = req0_ready_o || req1_ready_o;
    assign sel          = grant1;

    assign sel_op    = shift_op_e'(sel ? req1_op_i : req0_op_i);
    assign sel_data  = sel ? req1_data_i  : req0_data_i;
    assign sel_shamt = sel ? req1_shamt_i : req0_shamt_i;
    assign sel_tag   = sel ? req1_tag_i   : req0_tag_i;

    shift_core #(
        .DATA_W  (DATA_W),
        .SHAMT_W (SHAMT_W)
    ) u_shift_core (
        .a_i     (sel_data),
        .shamt_i (sel_shamt),
        .op_i    (sel_op),
        .s_o     (shift_res)
    );

    // Flush wins over a drain or a held result; a same-cycle accept overwrites.
    always_comb begin
        slot_d = slot_q;
        if (flush_i) begin
            slot_d = SLOT_EMPTY;
        end else if (accept) begin
            slot_d = SLOT_FULL;
        end else if (rsp_ready_i) begin
            slot_d = SLOT_EMPTY;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            slot_q <= SLOT_EMPTY;
        end else begin
            slot_q <= slot_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr        <= 1'b0;
            rsp_id_o   <= 1'b0;
            rsp_tag_o  <= '0;
            rsp_data_o <= '0;
        end else if (accept) begin
            ptr        <= ~sel;
            rsp_id_o   <= sel;
            rsp_tag_o  <= sel_tag;
            rsp_data_o <= shift_res;
        end
    end

    assign rsp_valid_o = (slot_q == SLOT_FULL);

endmodule

// File: tb/tb_shift_unit_arbiter.sv
// Randomized and directed bench for shift_unit_arbiter with a queue scoreboard
// and a transaction-level reference model of arbitration and slot occupancy.
module tb_shift_unit_arbiter;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [1:0]  req0_op, req1_op;
    logic [31:0] req0_data, req1_data;
    logic [4:0]  req0_shamt, req1_shamt;
    logic [3:0]  req0_tag, req1_tag;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [3:0]  rsp_tag;
    logic [31:0] rsp_data;

    typedef struct packed {
        logic        id;
        logic [3:0]  tag;
        logic [31:0] data;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    logic m_full = 1'b0;
    logic m_prio = 1'b0;

    shift_unit_arbiter dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .flush_i      (flush),
        .req0_valid_i (req0_valid),
        .req0_ready_o (req0_ready),
        .req0_op_i    (req0_op),
        .req0_data_i  (req0_data),
        .req0_shamt_i (req0_shamt),
        .req0_tag_i   (req0_tag),
        .req1_valid_i (req1_valid),
        .req1_ready_o (req1_ready),
        .req1_op_i    (req1_op),
        .req1_data_i  (req1_data),
        .req1_shamt_i (req1_shamt),
        .req1_tag_i   (req1_tag),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_id_o     (rsp_id),
        .rsp_tag_o    (rsp_tag),
        .rsp_data_o   (rsp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] d,
                                              input logic [4:0] sh);
        case (op)
            2'b00:   return d << sh;
            2'b01:   return d >> sh;
            2'b11:   return 32'($signed(d) >>> sh);
            default: return d;
        endcase
    endfunction

    // Reference model: evaluated late in the low phase, once inputs have settled.
    always @(negedge clk) begin
        logic can, g0, g1, acc, who;
        #3;
        if (!rst_n) begin
            q.delete();
            m_full = 1'b0;
            m_prio = 1'b0;
            chk("ready0_in_reset", {63'd0, req0_ready}, 64'd0);
            chk("ready1_in_reset", {63'd0, req1_ready}, 64'd0);
        end else begin
            chk("rsp_valid", {63'd0, rsp_valid}, {63'd0, m_full});
            can = (!m_full || rsp_ready) && !flush;
            if (req0_valid && req1_valid) begin
                who = m_prio;
            end else begin
                who = req1_valid;
            end
            g0  = (req0_valid || req1_valid) && !who && can;
            g1  = (req0_valid || req1_valid) && who && can;
            acc = g0 || g1;
            chk("ready0", {63'd0, req0_ready}, {63'd0, g0});
            chk("ready1", {63'd0, req1_ready}, {63'd0, g1});
            if (acc) begin
                if (who) q.push_back('{1'b1, req1_tag, ref_shift(req1_op, req1_data, req1_shamt)});
                else     q.push_back('{1'b0, req0_tag, ref_shift(req0_op, req0_data, req0_shamt)});
                m_prio = !who;
            end
            if (flush) begin
                if (m_full && !rsp_ready && q.size() > 0) void'(q.pop_front());
                m_full = 1'b0;
            end else if (acc) begin
                m_full = 1'b1;
            end else if (rsp_ready) begin
                m_full = 1'b0;
            end
        end
    end

    // Monitor: every handshake on the response channel pops and compares.
    always @(negedge clk) begin
        exp_t e;
        #4;
        if (rst_n && rsp_valid && rsp_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_rsp", {63'd0, rsp_valid}, 64'd0);
            end else begin
                e = q.pop_front();
                chk("rsp_id", {63'd0, rsp_id}, {63'd0, e.id});
                chk("rsp_tag", {60'd0, rsp_tag}, {60'd0, e.tag});
                chk("rsp_data", {32'd0, rsp_data}, {32'd0, e.data});
            end
        end
    end

    task automatic drive(input logic v0, input logic [1:0] o0, input logic [31:0] d0,
                         input logic [4:0] s0, input logic [3:0] t0,
                         input logic v1, input logic [1:0] o1, input logic [31:0] d1,
                         input logic [4:0] s1, input logic [3:0] t1,
                         input logic rr, input logic fl);
        @(negedge clk);
        req0_valid = v0; req0_op = o0; req0_data = d0; req0_shamt = s0; req0_tag = t0;
        req1_valid = v1; req1_op = o1; req1_data = d1; req1_shamt = s1; req1_tag = t1;
        rsp_ready  = rr; flush = fl;
    endtask

    task automatic idle(input logic rr);
        drive(0, 2'b00, 32'd0, 5'd0, 4'd0, 0, 2'b00, 32'd0, 5'd0, 4'd0, rr, 0);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        rsp_ready = 1'b1;
        req0_valid = 0; req0_op = 0; req0_data = 0; req0_shamt = 0; req0_tag = 0;
        req1_valid = 0; req1_op = 0; req1_data = 0; req1_shamt = 0; req1_tag = 0;

        // Reset state, with requests offered while still in reset.
        drive(1, 2'b01, 32'h1234_5678, 5'd3, 4'd1, 1, 2'b00, 32'h1, 5'd1, 4'd2, 1, 0);
        @(negedge clk);
        #1;
        chk("reset_valid", {63'd0, rsp_valid}, 64'd0);
        chk("reset_id", {63'd0, rsp_id}, 64'd0);
        chk("reset_tag", {60'd0, rsp_tag}, 64'd0);
        chk("reset_data", {32'd0, rsp_data}, 64'd0);
        idle(1);
        rst_n = 1'b1;

        // Both valid after reset: req0 first, then alternating.
        repeat (4) drive(1, 2'b11, 32'hF000_0000, 5'd4, 4'd5, 1, 2'b00, 32'h1, 5'd31, 4'd6, 1, 0);
        idle(1);

        // Single req0 SRL.
        drive(1, 2'b01, 32'h8000_0000, 5'd31, 4'd3, 0, 2'b00, 32'd0, 5'd0, 4'd0, 1, 0);
        idle(1);
        idle(1);

        // Backpressure: fill, hold for three cycles, then overwrite on ready.
        drive(1, 2'b00, 32'h0000_00FF, 5'd8, 4'd7, 0, 2'b00, 32'd0, 5'd0, 4'd0, 0, 0);
        repeat (3) drive(1, 2'b01, 32'hAAAA_5555, 5'd1, 4'd8, 1, 2'b11, 32'h8765_4321, 5'd12, 4'd9, 0, 0);
        drive(1, 2'b01, 32'hAAAA_5555, 5'd1, 4'd8, 1, 2'b11, 32'h8765_4321, 5'd12, 4'd9, 1, 0);
        idle(1);
        idle(1);

        // Flush with a held result and req1 waiting.
        drive(1, 2'b00, 32'h0F0F_0F0F, 5'd4, 4'd10, 0, 2'b00, 32'd0, 5'd0, 4'd0, 0, 0);
        drive(0, 2'b00, 32'd0, 5'd0, 4'd0, 1, 2'b01, 32'hCAFE_F00D, 5'd16, 4'd11, 0, 1);
        drive(0, 2'b00, 32'd0, 5'd0, 4'd0, 1, 2'b01, 32'hCAFE_F00D, 5'd16, 4'd11, 0, 0);
        idle(1);
        idle(1);

        // Shift-amount and opcode corners.
        for (int op = 0; op < 4; op++) begin
            drive(1, 2'(op), 32'h9ABC_DEF1, 5'd0, 4'(op), 0, 2'b00, 32'd0, 5'd0, 4'd0, 1, 0);
        end
        drive(0, 2'b00, 32'd0, 5'd0, 4'd0, 1, 2'b10, 32'hDEAD_BEEF, 5'd7, 4'd12, 1, 0);
        drive(1, 2'b11, 32'h7FFF_FFFF, 5'd31, 4'd13, 0, 2'b00, 32'd0, 5'd0, 4'd0, 1, 0);
        drive(1, 2'b11, 32'h8000_0000, 5'd31, 4'd14, 0, 2'b00, 32'd0, 5'd0, 4'd0, 1, 0);
        idle(1);
        idle(1);

        // Async reset while the slot is full: valid drops without a clock edge.
        drive(0, 2'b00, 32'd0, 5'd0, 4'd0, 1, 2'b00, 32'h3, 5'd2, 4'd15, 0, 0);
        idle(0);
        #1 rst_n = 1'b0;
        #1 chk("async_reset_valid", {63'd0, rsp_valid}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) drive(1, 2'b01, 32'hFFFF_0000, 5'd8, 4'd1, 1, 2'b00, 32'h0000_FFFF, 5'd8, 4'd2, 1, 0);
        idle(1);

        // Randomized traffic, with an occasional reset pulse.
        for (int n = 0; n < 3000; n++) begin
            drive($urandom_range(0, 3) != 0, 2'($urandom), $urandom, 5'($urandom), 4'($urandom),
                  $urandom_range(0, 2) != 0, 2'($urandom), $urandom, 5'($urandom), 4'($urandom),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
            if (n == 1500) reset_pulse();
        end

        repeat (3) idle(1);
        @(negedge clk);
        #5;
        chk("queue_drained", 64'(q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
